// File: rtl/code_checker_pkg.sv
// -----------------------------------------------------------------------------
// code_checker_pkg
// Shared definitions for the code checker: FSM state encoding and the default
// parameter values used by code_checker and lock_timer.
// -----------------------------------------------------------------------------
package code_checker_pkg;

  localparam int DEF_DIGITS      = 4;     // digits per code
  localparam int DEF_DIGIT_W     = 4;     // bits per digit (BCD)
  localparam int DEF_MAX_TRIES   = 3;     // consecutive failures before lockout
  localparam int DEF_LOCK_CYCLES = 1000;  // lockout duration in clock cycles

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/lock_timer.sv
// -----------------------------------------------------------------------------
// lock_timer
// Lockout duration timer. A start pulse raises busy at the same edge; busy then
// stays high for exactly LOCK_CYCLES cycles. The down-counter stops at zero and
// never wraps.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset (busy low, counter cleared)
//   start - begin a lockout period
//   busy  - registered, high while the lockout period runs
// -----------------------------------------------------------------------------
module lock_timer
  import code_checker_pkg::*;
#(
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy
);

  // The counter only needs to hold LOCK_CYCLES-1.
  localparam int              CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(LOCK_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      count <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      count <= LOAD;
    end else if (busy) begin
      // The edge that finds zero ends the period: LOCK_CYCLES edges in total.
      if (count == '0) busy  <= 1'b0;
      else             count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/code_checker.sv
// -----------------------------------------------------------------------------
// code_checker
// Keypad code checker. Digits are compared one at a time against a stored
// reference code (digit 0 in the MSBs); only a running all-equal flag is kept.
// After DIGITS digits a one-cycle match or mismatch pulse is produced.
// MAX_TRIES consecutive mismatches lock the checker for LOCK_CYCLES cycles.
// Input priority: rst > load_ref > clear > digit_valid.
//
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset
//   load_ref    - capture ref_code as the reference, abort entry, clear fails
//   ref_code    - reference code, DIGITS*DIGIT_W bits, digit 0 in the MSBs
//   digit_valid - digit_in holds an entered digit this cycle
//   digit_in    - entered digit
//   clear       - abort the current entry
//   match       - one-cycle pulse, entered code equals reference
//   mismatch    - one-cycle pulse, entered code differs from reference
//   locked      - high while in lockout
//   entry_count - digits accepted in the current entry
// -----------------------------------------------------------------------------
module code_checker
  import code_checker_pkg::*;
#(
  parameter int DIGITS      = DEF_DIGITS,
  parameter int DIGIT_W     = DEF_DIGIT_W,
  parameter int MAX_TRIES   = DEF_MAX_TRIES,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_ref,
  input  logic [DIGITS*DIGIT_W-1:0]    ref_code,
  input  logic                         digit_valid,
  input  logic [DIGIT_W-1:0]           digit_in,
  input  logic                         clear,
  output logic                         match,
  output logic                         mismatch,
  output logic                         locked,
  output logic [$clog2(DIGITS+1)-1:0]  entry_count
);

  localparam int REF_W = DIGITS * DIGIT_W;
  localparam int ECW   = $clog2(DIGITS + 1);
  // The fail counter never holds MAX_TRIES itself: reaching it means lockout.
  localparam int FW    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  localparam logic [ECW-1:0] LAST_IDX = ECW'(DIGITS - 1);
  localparam logic [FW-1:0]  LAST_TRY = FW'(MAX_TRIES - 1);

  state_t           state, state_n;
  logic [REF_W-1:0] ref_q, ref_n;
  logic [FW-1:0]    fail_cnt, fail_n;
  logic [ECW-1:0]   cnt_n;
  logic             eq_q, eq_n;
  logic             match_n, mismatch_n;
  logic             start, busy, active;
  logic             hit, all_eq;
  logic [DIGIT_W-1:0] ref_digit;

  lock_timer #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock_timer (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy)
  );

  // busy is a flop inside the timer, so locked is a registered output.
  assign locked = busy;

  // Reference digit k sits k digits below the MSB digit.
  assign ref_digit = ref_q[REF_W - DIGIT_W - DIGIT_W * int'(entry_count) +: DIGIT_W];
  assign hit       = (digit_in == ref_digit);
  // The first digit starts a fresh running flag.
  assign all_eq    = hit && ((entry_count == '0) || eq_q);

  // LOCKED with the timer already expired behaves as IDLE, so the first
  // cycle after lockout accepts input like any other idle cycle.
  assign active = (state != LOCKED) || !busy;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_n    = state;
    ref_n      = ref_q;
    fail_n     = fail_cnt;
    cnt_n      = entry_count;
    eq_n       = eq_q;
    match_n    = 1'b0;
    mismatch_n = 1'b0;
    start      = 1'b0;

    if (active) begin
      if (state == LOCKED) state_n = IDLE;

      if (load_ref) begin
        ref_n   = ref_code;
        fail_n  = '0;
        cnt_n   = '0;
        state_n = IDLE;
      end else if (clear) begin
        cnt_n   = '0;
        state_n = IDLE;
      end else if (digit_valid) begin
        if (entry_count == LAST_IDX) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (all_eq) begin
            match_n = 1'b1;
            fail_n  = '0;
          end else begin
            mismatch_n = 1'b1;
            if (fail_cnt == LAST_TRY) begin
              // The fail counter is unused while locked; clearing it now
              // leaves it at 0 when the lockout ends.
              fail_n  = '0;
              start   = 1'b1;
              state_n = LOCKED;
            end else begin
              fail_n = fail_cnt + 1'b1;
            end
          end
        end else begin
          cnt_n   = entry_count + 1'b1;
          eq_n    = all_eq;
          state_n = ENTRY;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ref_q       <= '0;
      fail_cnt    <= '0;
      entry_count <= '0;
      eq_q        <= 1'b0;
      match       <= 1'b0;
      mismatch    <= 1'b0;
    end else begin
      state       <= state_n;
      ref_q       <= ref_n;
      fail_cnt    <= fail_n;
      entry_count <= cnt_n;
      eq_q        <= eq_n;
      match       <= match_n;
      mismatch    <= mismatch_n;
    end
  end

endmodule

// File: tb/tb_code_checker.sv
// -----------------------------------------------------------------------------
// tb_code_checker
// Self-checking bench for code_checker with default parameters. Expected
// match/mismatch pulses are pushed to a scoreboard when the final digit is
// driven and compared by a negedge monitor; any pulse without a pending
// expectation is reported.
// -----------------------------------------------------------------------------
module tb_code_checker;
  import code_checker_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_ref;
  logic [15:0] ref_code;
  logic        digit_valid;
  logic [3:0]  digit_in;
  logic        clear;
  logic        match;
  logic        mismatch;
  logic        locked;
  logic [2:0]  entry_count;

  always #5 clk = ~clk;

  code_checker #(
    .DIGITS      (4),
    .DIGIT_W     (4),
    .MAX_TRIES   (3),
    .LOCK_CYCLES (1000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_ref    (load_ref),
    .ref_code    (ref_code),
    .digit_valid (digit_valid),
    .digit_in    (digit_in),
    .clear       (clear),
    .match       (match),
    .mismatch    (mismatch),
    .locked      (locked),
    .entry_count (entry_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   cyc;
    logic m;
    logic mm;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  typedef struct {
    logic [15:0] ref_v;
    logic [15:0] code;
    bit          exp_match;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pulse monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check("pulse_match", {31'd0, match}, {31'd0, e.m});
      check("pulse_mismatch", {31'd0, mismatch}, {31'd0, e.mm});
    end else if (match === 1'b1 || mismatch === 1'b1) begin
      check("unexpected_pulse", {30'd0, match, mismatch}, 32'd0);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] r);
    load_ref = 1'b1;
    ref_code = r;
    step();
    load_ref = 1'b0;
  endtask

  // Drive one digit; when it completes the code, queue the expected pulse.
  task automatic enter_digit(input logic [3:0] d, input logic [2:0] exp_cnt,
                             input bit last, input bit exp_match);
    digit_valid = 1'b1;
    digit_in    = d;
    if (last) sb.push_back('{cyc + 1, exp_match, !exp_match});
    step();
    digit_valid = 1'b0;
    check("entry_count", {29'd0, entry_count}, {29'd0, exp_cnt});
  endtask

  task automatic enter_code(input logic [15:0] code, input bit exp_match);
    logic [15:0] c;
    c = code;
    for (int i = 0; i < 4; i++)
      enter_digit(c[15-4*i -: 4], (i == 3) ? 3'd0 : 3'(i + 1), i == 3, exp_match);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int len;

    vecs[0] = '{16'h1234, 16'h1234, 1'b1};
    vecs[1] = '{16'h1234, 16'h1294, 1'b0};
    vecs[2] = '{16'h1234, 16'h2234, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 1'b1};
    vecs[4] = '{16'h9876, 16'h9876, 1'b1};
    vecs[5] = '{16'h9876, 16'h9875, 1'b0};

    rst = 1'b1; load_ref = 1'b0; ref_code = '0;
    digit_valid = 1'b0; digit_in = '0; clear = 1'b0;
    step(2);
    rst = 1'b0;
    check("rst_match", {31'd0, match}, 32'd0);
    check("rst_mismatch", {31'd0, mismatch}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_entry_count", {29'd0, entry_count}, 32'd0);

    // Table-driven codes; each load clears the fail counter.
    for (int i = 0; i < 6; i++) begin
      load(vecs[i].ref_v);
      enter_code(vecs[i].code, vecs[i].exp_match);
      step();
    end

    // Mismatch only after the 4th digit; fail counter becomes 1.
    load(16'h1234);
    enter_digit(4'd1, 3'd1, 1'b0, 1'b0);
    enter_digit(4'd2, 3'd2, 1'b0, 1'b0);
    enter_digit(4'd9, 3'd3, 1'b0, 1'b0);
    enter_digit(4'd4, 3'd0, 1'b1, 1'b0);
    step();
    check("fail_cnt_one", {30'd0, dut.fail_cnt}, 32'd1);

    // Two more wrong entries: the third mismatch locks.
    enter_code(16'h1111, 1'b0);
    check("locked_before_third", {31'd0, locked}, 32'd0);
    enter_code(16'h4321, 1'b0);
    check("locked_with_third", {31'd0, locked}, 32'd1);

    // Count locked cycles while hammering inputs that must be ignored.
    len = 1;
    while (locked === 1'b1 && len < 2000) begin
      digit_valid = (len < 100);
      digit_in    = 4'(len % 10);
      load_ref    = (len == 50);
      ref_code    = 16'hFFFF;
      clear       = (len == 60);
      step();
      if (locked === 1'b1) len++;
    end
    digit_valid = 1'b0; load_ref = 1'b0; clear = 1'b0;
    check("lock_length", len, 32'd1000);
    check("lock_entry_count", {29'd0, entry_count}, 32'd0);
    check("fail_cnt_after_lock", {30'd0, dut.fail_cnt}, 32'd0);
    // Reference unchanged by the ignored load_ref.
    enter_code(16'h1234, 1'b1);
    step();

    // Partial entry, clear, then a full correct entry: single match.
    enter_digit(4'd1, 3'd1, 1'b0, 1'b0);
    enter_digit(4'd2, 3'd2, 1'b0, 1'b0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_entry_count", {29'd0, entry_count}, 32'd0);
    enter_code(16'h1234, 1'b1);
    step();

    // clear collides with digit_valid: digit dropped.
    clear = 1'b1; digit_valid = 1'b1; digit_in = 4'd1;
    step();
    clear = 1'b0; digit_valid = 1'b0;
    check("clear_vs_digit", {29'd0, entry_count}, 32'd0);

    // load_ref collides with digit_valid: digit dropped, new reference active.
    enter_digit(4'd1, 3'd1, 1'b0, 1'b0);
    load_ref = 1'b1; ref_code = 16'h5678; digit_valid = 1'b1; digit_in = 4'd2;
    step();
    load_ref = 1'b0; digit_valid = 1'b0;
    check("load_vs_digit", {29'd0, entry_count}, 32'd0);
    enter_code(16'h5678, 1'b1);
    step();

    // Lock again, then reset at lockout cycle 500.
    enter_code(16'h0001, 1'b0);
    enter_code(16'h0002, 1'b0);
    enter_code(16'h0003, 1'b0);
    check("relock", {31'd0, locked}, 32'd1);
    step(499);
    check("locked_at_500", {31'd0, locked}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_unlocks", {31'd0, locked}, 32'd0);
    check("rst_lock_entry_count", {29'd0, entry_count}, 32'd0);
    // Reference is back to zero.
    enter_code(16'h1234, 1'b0);
    step();

    // Reset colliding with the final digit of an entry: no pulse.
    load(16'h1234);
    enter_digit(4'd1, 3'd1, 1'b0, 1'b0);
    enter_digit(4'd2, 3'd2, 1'b0, 1'b0);
    enter_digit(4'd3, 3'd3, 1'b0, 1'b0);
    rst = 1'b1; digit_valid = 1'b1; digit_in = 4'd4;
    step();
    rst = 1'b0; digit_valid = 1'b0;
    check("rst_mid_entry_count", {29'd0, entry_count}, 32'd0);
    step(3);

    check("scoreboard_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
